// File: rtl/nbody_pkg.sv
// Shared constants and FSM state type for the N-body pair scheduler.
package nbody_pkg;

    localparam int MAX_BODIES   = 512;
    localparam int IDX_W        = 9;
    localparam int PIPE_LATENCY = 122;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FORCE  = 3'd1,
        DRAIN  = 3'd2,
        UPDATE = 3'd3,
        FIN    = 3'd4
    } state_t;

endpackage

// File: rtl/nbody_pair_scheduler_if.sv
// Force-pipeline issue/result and integrator handshakes of the pair scheduler.
interface nbody_pair_scheduler_if #(
    parameter int IDX_W = nbody_pkg::IDX_W
);
    logic             issue_valid;
    logic             issue_ready;
    logic [IDX_W-1:0] issue_i;
    logic [IDX_W-1:0] issue_j;
    logic             issue_last;
    logic             result_valid;
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_idx;

    modport master (
        output issue_valid, issue_i, issue_j, issue_last, upd_valid, upd_idx,
        input  issue_ready, result_valid, upd_ready
    );

    modport slave (
        input  issue_valid, issue_i, issue_j, issue_last, upd_valid, upd_idx,
        output issue_ready, result_valid, upd_ready
    );
endinterface

// File: rtl/nbody_pair_counter.sv
// (i,j) pair generator: j fastest, i outer, diagonal skipped, last-j flag per row.
module nbody_pair_counter #(
    parameter int IDX_W = nbody_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [IDX_W:0]   n_bodies,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic             last,
    output logic             final_pair
);
    logic [IDX_W-1:0] i_r;
    logic [IDX_W-1:0] j_r;
    logic [IDX_W-1:0] i_next_s;
    logic [IDX_W-1:0] j_next_s;
    logic [IDX_W:0]   n_m1_s;
    logic [IDX_W:0]   n_m2_s;
    logic             last_s;
    logic             final_s;

    assign n_m1_s  = n_bodies - (IDX_W+1)'(1);
    assign n_m2_s  = n_bodies - (IDX_W+1)'(2);
    // The last row ends one early because its diagonal element is the final j.
    assign final_s = ({1'b0, i_r} == n_m1_s) && ({1'b0, j_r} == n_m2_s);
    assign last_s  = ({1'b0, j_r} == n_m1_s) || final_s;

    // Next pair: wrap to the next row on last, otherwise step j over the diagonal.
    always_comb begin
        i_next_s = i_r;
        j_next_s = j_r;
        if (clear) begin
            i_next_s = '0;
            j_next_s = IDX_W'(1);
        end else if (advance) begin
            if (last_s) begin
                i_next_s = i_r + IDX_W'(1);
                j_next_s = '0;
            end else if ((j_r + IDX_W'(1)) == i_r) begin
                j_next_s = j_r + IDX_W'(2);
            end else begin
                j_next_s = j_r + IDX_W'(1);
            end
        end else begin
            i_next_s = i_r;
            j_next_s = j_r;
        end
    end

    // Pair index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_r <= '0;
            j_r <= '0;
        end else begin
            i_r <= i_next_s;
            j_r <= j_next_s;
        end
    end

    assign i          = i_r;
    assign j          = j_r;
    assign last       = last_s;
    assign final_pair = final_s;
endmodule

// File: rtl/nbody_pair_scheduler.sv
// Schedules all-pairs force evaluation, pipeline drain and per-body integration over multiple timesteps.
module nbody_pair_scheduler #(
    parameter int MAX_BODIES = nbody_pkg::MAX_BODIES,
    parameter int IDX_W      = nbody_pkg::IDX_W,
    parameter int STEP_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IDX_W:0]      n_bodies,
    input  logic [STEP_W-1:0]   steps,
    output logic                busy,
    output logic                done,
    output logic [STEP_W-1:0]   step_count,
    output logic                err,
    nbody_pair_scheduler_if.master bus
);
    import nbody_pkg::*;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W:0]     n_r;
    logic [STEP_W-1:0]  steps_r;
    logic [STEP_W-1:0]  step_count_r;
    logic [STEP_W-1:0]  step_inc_s;
    logic [2*IDX_W-1:0] out_r;
    logic [2*IDX_W-1:0] out_next_s;
    logic [IDX_W-1:0]   upd_idx_r;
    logic [IDX_W:0]     n_sat_s;
    logic [IDX_W:0]     n_m1_s;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic               issue_valid_r;
    logic               upd_valid_r;
    logic               issue_fire_s;
    logic               upd_fire_s;
    logic               res_ok_s;
    logic               spurious_s;
    logic               start_ok_s;
    logic               step_end_s;
    logic               pair_clear_s;
    logic [IDX_W-1:0]   pair_i_s;
    logic [IDX_W-1:0]   pair_j_s;
    logic               pair_last_s;
    logic               pair_final_s;

    // Counts above the supported maximum are clamped rather than running off the index range.
    assign n_sat_s      = (n_bodies > (IDX_W+1)'(MAX_BODIES)) ? (IDX_W+1)'(MAX_BODIES) : n_bodies;
    assign n_m1_s       = n_r - (IDX_W+1)'(1);
    assign issue_fire_s = issue_valid_r & bus.issue_ready;
    assign upd_fire_s   = upd_valid_r & bus.upd_ready;
    assign res_ok_s     = bus.result_valid & (out_r != '0);
    assign spurious_s   = bus.result_valid & (out_r == '0);
    assign start_ok_s   = start & ((state_r == IDLE) | (state_r == FIN));
    assign step_end_s   = upd_fire_s & ({1'b0, upd_idx_r} == n_m1_s);
    assign step_inc_s   = step_count_r + STEP_W'(1);

    nbody_pair_counter #(.IDX_W(IDX_W)) u_pair_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (pair_clear_s),
        .advance    (issue_fire_s),
        .n_bodies   (n_r),
        .i          (pair_i_s),
        .j          (pair_j_s),
        .last       (pair_last_s),
        .final_pair (pair_final_s)
    );

    // Next-state logic; a single body has no pairs so it goes straight to integration.
    always_comb begin
        state_next_s = state_r;
        pair_clear_s = 1'b0;
        case (state_r)
            IDLE, FIN: begin
                if (start) begin
                    pair_clear_s = 1'b1;
                    if ((n_sat_s == '0) || (steps == '0)) begin
                        state_next_s = FIN;
                    end else if (n_sat_s == (IDX_W+1)'(1)) begin
                        state_next_s = UPDATE;
                    end else begin
                        state_next_s = FORCE;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            FORCE: begin
                if (issue_fire_s && pair_final_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = FORCE;
                end
            end
            DRAIN: begin
                if (out_r == '0) begin
                    state_next_s = UPDATE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            UPDATE: begin
                if (step_end_s) begin
                    if (step_inc_s == steps_r) begin
                        state_next_s = FIN;
                    end else begin
                        pair_clear_s = 1'b1;
                        state_next_s = (n_r == (IDX_W+1)'(1)) ? UPDATE : FORCE;
                    end
                end else begin
                    state_next_s = UPDATE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // In-flight pair count; a simultaneous issue and return cancel out.
    always_comb begin
        case ({issue_fire_s, res_ok_s})
            2'b10:   out_next_s = out_r + (2*IDX_W)'(1);
            2'b01:   out_next_s = out_r - (2*IDX_W)'(1);
            default: out_next_s = out_r;
        endcase
    end

    // State, outputs decoded one cycle ahead from the next state, and run bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            issue_valid_r <= 1'b0;
            upd_valid_r   <= 1'b0;
            n_r           <= '0;
            steps_r       <= '0;
            step_count_r  <= '0;
            out_r         <= '0;
            upd_idx_r     <= '0;
        end else begin
            state_r       <= state_next_s;
            busy_r        <= (state_next_s == FORCE) | (state_next_s == DRAIN) | (state_next_s == UPDATE);
            done_r        <= (state_next_s == FIN);
            issue_valid_r <= (state_next_s == FORCE);
            upd_valid_r   <= (state_next_s == UPDATE);
            err_r         <= start_ok_s ? 1'b0 : (err_r | spurious_s);
            out_r         <= out_next_s;
            if (start_ok_s) begin
                n_r          <= n_sat_s;
                steps_r      <= steps;
                step_count_r <= '0;
            end else if (step_end_s) begin
                step_count_r <= step_inc_s;
            end else begin
                step_count_r <= step_count_r;
            end
            if (upd_fire_s) begin
                upd_idx_r <= step_end_s ? '0 : (upd_idx_r + IDX_W'(1));
            end else begin
                upd_idx_r <= upd_idx_r;
            end
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;
    assign step_count      = step_count_r;
    assign bus.issue_valid = issue_valid_r;
    assign bus.issue_i     = pair_i_s;
    assign bus.issue_j     = pair_j_s;
    assign bus.issue_last  = pair_last_s;
    assign bus.upd_valid   = upd_valid_r;
    assign bus.upd_idx     = upd_idx_r;
endmodule
